// File: rtl/sqrt2_drv_pkg.sv
// Shared types and constants for the sqrt2 core bus driver and its result FIFO.
package sqrt2_drv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [15:0] FP16_QNAN     = 16'h7E00;
  localparam logic [15:0] FP16_NEG_QNAN = 16'hFE00;
  localparam logic [15:0] FP16_PINF     = 16'h7C00;

  typedef struct packed {
    logic [15:0] data;
    logic        nan;
    logic        pinf;
    logic        timeout;
  } result_t;

endpackage

// File: rtl/sqrt2_result_fifo.sv
// First-word fall-through result queue; head fields read as zero while empty.
module sqrt2_result_fifo
  import sqrt2_drv_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic    CLK,
  input  logic    RST,
  input  logic    push,
  input  result_t push_entry,
  input  logic    pop,
  output result_t head,
  output logic    valid,
  output logic    full
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

  result_t       mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_pop;

  assign valid  = (count != '0);
  assign full   = (count == DEPTH_C);
  assign do_pop = pop && valid;

  // NOTE: storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sqrt2_bus_driver.sv
// Sequencer for the FP16 sqrt2 core: loads an operand over the shared bus, waits for
// RESULT (or times out), restarts the core and queues the captured result.
module sqrt2_bus_driver
  import sqrt2_drv_pkg::*;
#(
  parameter int OUT_DEPTH = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_nan,
  output logic        out_pinf,
  output logic        out_timeout,
  output logic        busy,
  inout  wire  [15:0] SQ_DATA,
  output logic        SQ_ENABLE,
  input  logic        SQ_IS_NAN,
  input  logic        SQ_IS_PINF,
  input  logic        SQ_RESULT
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [15:0]   operand;
  logic [15:0]   operand_next;
  logic          push;
  result_t       push_entry;
  result_t       head;
  logic          fifo_valid;
  logic          fifo_full;

  // A result slot is reserved at acceptance, so a full FIFO blocks new operands.
  assign in_ready  = (state == IDLE) && !fifo_full;
  assign busy      = (state != IDLE);
  assign SQ_ENABLE = (state == LOAD) || (state == RUN);
  assign SQ_DATA   = (state == LOAD) ? operand : 16'hzzzz;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      timer   <= '0;
      operand <= '0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      operand <= operand_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    operand_next = operand;
    push         = 1'b0;
    push_entry   = '0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          operand_next = in_data;
          state_next   = LOAD;
        end
      end
      LOAD: state_next = RUN;
      RUN: begin
        if (SQ_RESULT) begin
          push       = 1'b1;
          push_entry = '{data: SQ_DATA, nan: SQ_IS_NAN, pinf: SQ_IS_PINF, timeout: 1'b0};
          state_next = RECOVER;
        end else if (timer == TIMER_LAST) begin
          push       = 1'b1;
          push_entry = '{data: FP16_QNAN, nan: 1'b1, pinf: 1'b0, timeout: 1'b1};
          state_next = RECOVER;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      RECOVER: begin
        timer_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  sqrt2_result_fifo #(
    .OUT_DEPTH(OUT_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_entry(push_entry),
    .pop       (out_ready),
    .head      (head),
    .valid     (fifo_valid),
    .full      (fifo_full)
  );

  assign out_valid   = fifo_valid;
  assign out_data    = head.data;
  assign out_nan     = head.nan;
  assign out_pinf    = head.pinf;
  assign out_timeout = head.timeout;

endmodule

// File: doc/sqrt2_bus_driver.md
Name: sqrt2_bus_driver

Overview:
- Upstream sequencer for the half-precision square-root core (`sqrt2`).
- Accepts FP16 operands over a valid/ready stream and drives the core's ENABLE / shared bidirectional data bus.
- Waits for RESULT, captures the result word and flags, and queues them in a small output FIFO for a valid/ready consumer.
- Owns bus turnaround, core restart (ENABLE low pulse) and a hang timeout.

Parameters:
- OUT_DEPTH, 2, result FIFO entries; power of two, ≥2.
- TIMEOUT, 16, maximum RUN cycles without SQ_RESULT before abort.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid && in_ready at posedge.
- in_data  input  16  FP16 operand.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer pop.
- out_data  output  16  FP16 result.
- out_nan  output  1  core IS_NAN captured.
- out_pinf  output  1  core IS_PINF captured.
- out_timeout  output  1  entry produced by timeout abort.
- busy  output  1  state != IDLE.
- SQ_DATA  inout  16  core shared bus.
- SQ_ENABLE  output  1  core ENABLE.
- SQ_IS_NAN  input  1  core flag.
- SQ_IS_PINF  input  1  core flag.
- SQ_RESULT  input  1  core result-ready.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; SQ_ENABLE=0; SQ_DATA released (Z).
  - FIFO empty; out_valid=0; out_data/flags=0; busy=0; timer=0.
- Core contract:
  - Core samples SQ_DATA at its first enabled posedge (E1).
  - Core keeps the bus Z until E2, then drives it continuously.
  - Core asserts SQ_RESULT after E12 for finite/zero/negative operands, and after E2 for NaN, +Inf and -0.
  - A falling SQ_ENABLE clears the core.
- State machine:
  - IDLE: in_ready = (fifo_count < OUT_DEPTH). On handshake at edge E0, latch in_data, go LOAD.
  - LOAD (1 cycle, E0→E1): SQ_ENABLE=1, SQ_DATA driven with latched operand. At E1, go RUN.
  - RUN: SQ_ENABLE=1, SQ_DATA released (one-cycle dead time before the core drives), timer increments each cycle.
    - If SQ_RESULT=1 at a posedge: push {SQ_DATA, SQ_IS_NAN, SQ_IS_PINF, timeout=0}, go RECOVER.
    - Else if timer==TIMEOUT-1: push {16'h7E00, nan=1, pinf=0, timeout=1}, go RECOVER.
  - RECOVER (1 cycle): SQ_ENABLE=0, timer cleared, then IDLE.
- Bus rules:
  - The driver's output enable is high only in LOAD; it is never high in any other state or during reset.
  - Core IS_NINF is not connected or captured.
- Latency (handshake edge to out_valid high, empty FIFO):
  - Normal operands: 13 cycles (push at E13).
  - NaN/+Inf/-0: 3 cycles.
  - Throughput: one operation per 14 cycles normal, 4 cycles special.
- FIFO:
  - First-word fall-through; out_* reflect the head entry.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Overflow is impossible: the slot is reserved at acceptance and only one operation is in flight.
  - Pointers wrap modulo OUT_DEPTH.
- Reset mid-operation:
  - SQ_ENABLE falls immediately, clearing the core.
  - Any in-flight result is discarded; queued results are lost.
- in_data changes while in_ready=0 are ignored; the latched operand is stable through LOAD.

Decomposition:
- Package sqrt2_drv_pkg:
  - state enum {IDLE, LOAD, RUN, RECOVER}.
  - Constants FP16_QNAN=16'h7E00, FP16_NEG_QNAN=16'hFE00, FP16_PINF=16'h7C00.
  - Result entry struct {data[15:0], nan, pinf, timeout}.
- One sub-module: sqrt2_result_fifo (parameterised OUT_DEPTH, async active-high reset, FWFT), carrying the struct.

Test Plan:
- Operand 16'h4400 (4.0) with the real core, out_ready=1 → out_data=16'h4000, nan=0, pinf=0, timeout=0, out_valid exactly 13 cycles after handshake.
- Operand 16'h7C00 (+Inf) → out_data=16'h7C00, pinf=1, latency 3; next in_ready high 4 cycles after first handshake.
- Operand 16'hC400 (-4.0) → out_data=16'hFE00, nan=1, latency 13. Operand 16'h8000 (-0) → out_data=16'h8000, nan=0.
- Back-pressure, OUT_DEPTH=2, out_ready=0, three back-to-back operands 4400/3C00/4880:
  - in_ready low after second result is pushed; third held.
  - Raise out_ready → outputs 4000, 3C00, 4200 in order, no loss or duplicates.
- Behavioural core model that never raises SQ_RESULT → out_data=16'h7E00, nan=1, timeout=1 pushed TIMEOUT+1 cycles after handshake; SQ_ENABLE low for one cycle, then in_ready=1.
- Bus assertions on every operation: SQ_DATA never X during RUN after E2; driver output enable high only during LOAD.
- RST pulsed mid-RUN → SQ_ENABLE=0, bus Z, out_valid=0, busy=0 within the same cycle. Next 16'h4400 still produces 16'h4000.
